// File: rtl/qar_mem_arbiter.sv
// qar_mem_arbiter: shares one single-port synchronous memory between the
// instruction-fetch path and the load/store path. Data wins by default, a
// saturating starvation counter forces fetch through, and a lock lets the
// data side chain atomic sequences without fetch slipping in between.
module qar_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  // Owner of the read issued in the previous cycle
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             lock_q, lock_d;
  logic [1:0]       resp_own_q, resp_own_d;
  logic             if_gnt_s, d_gnt_s;

  // Grant decision: lock, then starvation override, then data priority
  always_comb begin
    if_gnt_s = 1'b0;
    d_gnt_s  = 1'b0;
    if (!rst_n) begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end else if (lock_q) begin
      d_gnt_s = d_req;
    end else if (if_req && (starve_cnt_q == CNT_MAX)) begin
      if_gnt_s = 1'b1;
    end else if (d_req) begin
      d_gnt_s = 1'b1;
    end else if (if_req) begin
      if_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end
  end

  assign if_gnt = if_gnt_s;
  assign d_gnt  = d_gnt_s;

  // Memory port mux; fetch never writes, idle port drives all zeros
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (d_gnt_s) begin
      mem_en    = 1'b1;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_we    = d_we;
    end else if (if_gnt_s) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Next-state for starvation counter, lock and response owner
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    lock_d       = lock_q;
    resp_own_d   = OWN_NONE;

    if (if_gnt_s || !if_req) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end

    // Dropping d_req releases the lock so a stalled LSU cannot wedge fetch
    if (d_gnt_s) begin
      lock_d = d_lock;
    end else if (!d_req) begin
      lock_d = 1'b0;
    end else begin
      lock_d = lock_q;
    end

    if (if_gnt_s) begin
      resp_own_d = OWN_IF;
    end else if (d_gnt_s && !d_we) begin
      resp_own_d = OWN_D;
    end else begin
      resp_own_d = OWN_NONE;
    end
  end

  // State registers; reset also discards any in-flight read response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      lock_q       <= 1'b0;
      resp_own_q   <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      lock_q       <= lock_d;
      resp_own_q   <= resp_own_d;
    end
  end

  // Steer read data to whichever requester issued last cycle's read
  assign if_rvalid = (resp_own_q == OWN_IF);
  assign d_rvalid  = (resp_own_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_qar_mem_arbiter.sv
// Self-checking bench for qar_mem_arbiter: a small memory model answers
// reads one cycle late, expected responses are queued at grant time and
// popped when the response cycle arrives.
module tb_qar_mem_arbiter;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_IF   = 2'd1;
  localparam logic [1:0] G_D    = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_lock;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [1:0]  own;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem_arr [0:255];

  qar_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, read data valid the next cycle
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
      mem_rdata <= 32'hBAD0_BAD0;
    end else if (mem_en) begin
      mem_rdata <= mem_arr[mem_addr[9:2]];
    end else begin
      mem_rdata <= 32'hBAD0_BAD0;
    end
  end

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return mem_arr[a[9:2]];
  endfunction

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic dl);
    @(negedge clk);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dwd;
    d_lock  = dl;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0080;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
    d_wdata = 32'h0000_0000; d_lock = 1'b0;
    #51;
    total++;
    if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid,
         mem_addr, mem_wdata, if_rdata, d_rdata} !== 134'd0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%b%b en=%b we=%b rv=%b%b addr=%h wdata=%h, required all 0",
               if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_en !== 1'b1 ||
        mem_addr !== 32'h0000_0040 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_grant: d_gnt=%b if_gnt=%b mem_en=%b addr=%h we=%b, required 1 0 1 00000040 0",
               d_gnt, if_gnt, mem_en, mem_addr, mem_we);
    end
    exp_q.push_back('{G_D, rd_model(32'h0000_0040)});
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== e.data || if_rvalid !== 1'b0 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_read: d_rvalid=%b d_rdata=%h if_rvalid=%b mem_en=%b, required 1 %h 0 0",
               d_rvalid, d_rdata, if_rvalid, mem_en, e.data);
    end
  endtask

  task automatic test_single_fetch();
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    total++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== 32'h0000_0100 ||
        mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL fetch_issue: if_gnt=%b d_gnt=%b addr=%h we=%b wdata=%h, required 1 0 00000100 0 0",
               if_gnt, d_gnt, mem_addr, mem_we, mem_wdata);
    end
    exp_q.push_back('{G_IF, 32'hDEAD_BEEF});
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== e.data || d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL fetch_response: if_rvalid=%b if_rdata=%h d_rvalid=%b d_rdata=%h, required 1 %h 0 0",
               if_rvalid, if_rdata, d_rvalid, d_rdata, e.data);
    end
  endtask

  task automatic test_write();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0);
    total++;
    if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
        mem_addr !== 32'h0000_0020 || mem_wdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL write_issue: d_gnt=%b en=%b we=%b addr=%h wdata=%h, required 1 1 1 00000020 12345678",
               d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    // Fetch the written word back in the very next cycle
    drive(1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    total++;
    if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL write_no_response: d_rvalid=%b if_rvalid=%b d_rdata=%h, required 0 0 0",
               d_rvalid, if_rvalid, d_rdata);
    end
    exp_q.push_back('{G_IF, 32'h1234_5678});
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== e.data) begin
      bad++;
      $display("FAIL write_readback: if_rvalid=%b if_rdata=%h, required 1 %h", if_rvalid, if_rdata, e.data);
    end
  endtask

  task automatic test_contention();
    int          nif = 0;
    int          nd  = 0;
    int          denied = 0;
    logic [1:0]  g;
    logic [31:0] ia, da;
    for (int k = 0; k < 15; k++) begin
      ia = 32'h0000_0300 + 32'(4 * nif);
      da = 32'h0000_0200 + 32'(4 * nd);
      drive(1'b1, ia, 1'b1, 1'b0, da, 32'hFFFF_0000, 1'b0);
      g = ((k % 5) == 4) ? G_IF : G_D;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (if_rvalid !== (e.own == G_IF) || d_rvalid !== (e.own == G_D) ||
            if_rdata !== ((e.own == G_IF) ? e.data : 32'h0) ||
            d_rdata !== ((e.own == G_D) ? e.data : 32'h0)) begin
          bad++;
          $display("FAIL contention_rsp cyc %0d: rv=%b%b if_rdata=%h d_rdata=%h, required own=%0d data=%h",
                   k, if_rvalid, d_rvalid, if_rdata, d_rdata, e.own, e.data);
        end
      end
      total++;
      if (if_gnt !== (g == G_IF) || d_gnt !== (g == G_D) || mem_en !== 1'b1) begin
        bad++;
        $display("FAIL contention_grant cyc %0d: if_gnt=%b d_gnt=%b en=%b, required grant=%0d",
                 k, if_gnt, d_gnt, mem_en, g);
      end
      if (if_gnt === 1'b1) denied = 0;
      else denied++;
      total++;
      if (denied > 4) begin
        bad++;
        $display("FAIL starvation_bound cyc %0d: denied=%0d, required <=4", k, denied);
      end
      if (g == G_IF) begin
        exp_q.push_back('{G_IF, rd_model(ia)});
        nif++;
      end else begin
        exp_q.push_back('{G_D, rd_model(da)});
        nd++;
      end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (if_rvalid !== (e.own == G_IF) || d_rvalid !== (e.own == G_D) ||
        if_rdata !== ((e.own == G_IF) ? e.data : 32'h0) ||
        d_rdata !== ((e.own == G_D) ? e.data : 32'h0)) begin
      bad++;
      $display("FAIL contention_drain: rv=%b%b if_rdata=%h d_rdata=%h, required own=%0d data=%h",
               if_rvalid, d_rvalid, if_rdata, d_rdata, e.own, e.data);
    end
  endtask

  task automatic test_lock();
    logic [1:0]  g;
    logic        ir, dr, dw, dl;
    logic [31:0] da, dwd;
    // Locked reads 0..4 push the counter to saturation; 5 unlocks with a
    // write; 6 must go to fetch even with d_req high; 7 data again; 8 idle
    for (int k = 0; k < 9; k++) begin
      ir  = (k <= 6);
      dr  = (k <= 7);
      dw  = (k == 5);
      dl  = (k <= 4);
      da  = 32'h0000_0040 + 32'(4 * k);
      dwd = 32'hCAFE_0000 + 32'(k);
      g   = (k == 6) ? G_IF : ((k <= 7) ? G_D : G_NONE);
      drive(ir, 32'h0000_0100, dr, dw, da, dwd, dl);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (if_rvalid !== (e.own == G_IF) || d_rvalid !== (e.own == G_D) ||
            if_rdata !== ((e.own == G_IF) ? e.data : 32'h0) ||
            d_rdata !== ((e.own == G_D) ? e.data : 32'h0)) begin
          bad++;
          $display("FAIL lock_rsp cyc %0d: rv=%b%b if_rdata=%h d_rdata=%h, required own=%0d data=%h",
                   k, if_rvalid, d_rvalid, if_rdata, d_rdata, e.own, e.data);
        end
      end
      total++;
      if (if_gnt !== (g == G_IF) || d_gnt !== (g == G_D) || mem_en !== (g != G_NONE)) begin
        bad++;
        $display("FAIL lock_grant cyc %0d: if_gnt=%b d_gnt=%b en=%b, required grant=%0d",
                 k, if_gnt, d_gnt, mem_en, g);
      end
      if (g == G_IF) exp_q.push_back('{G_IF, rd_model(32'h0000_0100)});
      else if (g == G_D && !dw) exp_q.push_back('{G_D, rd_model(da)});
      else exp_q.push_back('{G_NONE, 32'h0});
    end
    exp_q.delete();
  endtask

  task automatic test_lock_drop();
    drive(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 1'b1);
    total++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      bad++;
      $display("FAIL lockdrop_take: d_gnt=%b if_gnt=%b, required 1 0", d_gnt, if_gnt);
    end
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    total++;
    if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL lockdrop_held: if_gnt=%b d_gnt=%b en=%b, required 0 0 0", if_gnt, d_gnt, mem_en);
    end
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    total++;
    if (if_gnt !== 1'b1 || mem_addr !== 32'h0000_0100) begin
      bad++;
      $display("FAIL lockdrop_release: if_gnt=%b addr=%h, required 1 00000100", if_gnt, mem_addr);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    drive(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0048, 32'h0, 1'b1);
    total++;
    if (d_gnt !== 1'b1) begin
      bad++;
      $display("FAIL midreset_grant: d_gnt=%b, required 1", d_gnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    total++;
    if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || d_rdata !== 32'h0 ||
        d_gnt !== 1'b0 || if_gnt !== 1'b0 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL midreset_quiet: rv=%b%b d_rdata=%h gnt=%b%b en=%b, required all 0",
               if_rvalid, d_rvalid, d_rdata, if_gnt, d_gnt, mem_en);
    end
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    d_req  = 1'b0;
    d_lock = 1'b0;
    #1;
    total++;
    if (dut.lock_q !== 1'b0 || dut.starve_cnt_q !== 3'd0) begin
      bad++;
      $display("FAIL midreset_state: lock_q=%b starve_cnt=%0d, required 0 0", dut.lock_q, dut.starve_cnt_q);
    end
    total++;
    if (if_gnt !== 1'b1 || d_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_after: if_gnt=%b d_rvalid=%b, required 1 0", if_gnt, d_rvalid);
    end
    exp_q.push_back('{G_IF, 32'hDEAD_BEEF});
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== e.data || d_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_fetch: if_rvalid=%b if_rdata=%h d_rvalid=%b, required 1 %h 0",
               if_rvalid, if_rdata, d_rvalid, e.data);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hC0DE_0000 | 32'(i);
    mem_arr[64] = 32'hDEAD_BEEF;
    test_reset();
    test_single_fetch();
    test_write();
    test_contention();
    test_lock();
    test_lock_drop();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
